// File: rtl/altair_pkg.sv
// Shared constants and state encoding for the Altair front-panel loader.
package altair_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHECK
  } loader_state_t;

endpackage

// File: rtl/altair_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU status lines of the loader.
interface altair_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  altair_we;
  logic [ADDR_WIDTH-1:0] altair_waddr;
  logic [15:0]           altair_wdata;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, altair_we, altair_waddr, altair_wdata,
           cpu_hold, load_done, load_error
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, altair_we, altair_waddr, altair_wdata,
           cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/altair_timeout.sv
// Inter-byte idle counter; pulses expired on the cycle the idle run reaches TIMEOUT_CYCLES.
module altair_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic kick,
  output logic expired
);

  logic [31:0] cnt_q, cnt_d;
  logic        hit;

  always_comb begin
    // cnt_q counts idle edges already seen, so this edge is idle edge number cnt_q+1.
    hit   = (TIMEOUT_CYCLES != 0) && active && !kick && (cnt_q == TIMEOUT_CYCLES - 1);
    cnt_d = cnt_q + 32'd1;
    if (!active || kick || hit) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = hit;

endmodule

// File: rtl/altair_loader.sv
// Framed byte-stream loader: parses packets, writes 16-bit words to instruction memory, verifies XOR checksum.
module altair_loader
  import altair_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  altair_loader_if.master bus
);

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [7:0]            xor_q, xor_d;
  logic [7:0]            byte_q, byte_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rdy_q;
  logic                  accept;
  logic                  expired;

  assign accept = bus.rx_valid && rdy_q;

  altair_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .active (state_q != ST_IDLE),
    .kick   (accept),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    byte_d  = byte_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if (expired) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (accept) begin
      // byte_q holds whichever high byte (address, count or data) the next byte completes.
      if (state_q != ST_IDLE && state_q != ST_CHECK) begin
        xor_d = xor_q ^ bus.rx_data;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == SYNC_BYTE) begin
            hold_d  = 1'b1;
            err_d   = 1'b0;
            xor_d   = '0;
            state_d = ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: begin
          byte_d  = bus.rx_data;
          state_d = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          addr_d  = ADDR_WIDTH'({byte_q, bus.rx_data});
          state_d = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          byte_d  = bus.rx_data;
          state_d = ST_CNT_LO;
        end
        ST_CNT_LO: begin
          cnt_d   = {byte_q, bus.rx_data};
          state_d = ({byte_q, bus.rx_data} == '0) ? ST_CHECK : ST_DATA_HI;
        end
        ST_DATA_HI: begin
          byte_d  = bus.rx_data;
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {byte_q, bus.rx_data};
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = cnt_q - CNT_WIDTH'(1);
          state_d = (cnt_q == CNT_WIDTH'(1)) ? ST_CHECK : ST_DATA_HI;
        end
        ST_CHECK: begin
          if (bus.rx_data == xor_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      xor_q   <= '0;
      byte_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      byte_q  <= byte_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  assign bus.rx_ready     = rdy_q;
  assign bus.altair_we    = we_q;
  assign bus.altair_waddr = waddr_q;
  assign bus.altair_wdata = wdata_q;
  assign bus.cpu_hold     = hold_q;
  assign bus.load_done    = done_q;
  assign bus.load_error   = err_q;

endmodule

// File: tb/tb_altair_loader.sv
// Self-checking bench for altair_loader: literal frames for corner cases plus randomized frames from a table.
module tb_altair_loader;

  localparam int AW    = 14;
  localparam int MEMSZ = 1 << AW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  altair_loader_if #(.ADDR_WIDTH(AW)) bus ();

  altair_loader #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] addr;
    int          nwords;
    bit          bad;
    int          max_gap;
    bit          exp_done;
    bit          exp_err;
    bit          exp_hold;
  } vec_t;

  wr_t        exp_wq[$];
  logic [7:0] frame_q[$];
  vec_t       vecs[6];
  int         errors   = 0;
  int         checks   = 0;
  int         done_cnt = 0;
  int         d0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_write(input int a, input logic [15:0] d);
    wr_t w;
    w.addr = a % MEMSZ;
    w.data = d;
    exp_wq.push_back(w);
  endtask

  function automatic logic [7:0] frame_xor();
    logic [7:0] x = 8'h00;
    for (int i = 1; i < frame_q.size(); i++) x ^= frame_q[i];
    return x;
  endfunction

  // Reference model: a frame is a list of words at consecutive (wrapping) addresses.
  task automatic make_frame(input logic [15:0] addr, input int n, input bit bad);
    logic [15:0] w;
    logic [7:0]  c;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(addr[15:8]);
    frame_q.push_back(addr[7:0]);
    frame_q.push_back(8'((n >> 8) & 255));
    frame_q.push_back(8'(n & 255));
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      frame_q.push_back(w[15:8]);
      frame_q.push_back(w[7:0]);
      expect_write(int'(addr) + i, w);
    end
    c = frame_xor();
    if (bad) c ^= 8'h5A;
    frame_q.push_back(c);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_q(input int max_gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(frame_q[i]);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.rx_ready), 0);
    chk({tag, "_we"},    32'(bus.altair_we), 0);
    chk({tag, "_waddr"}, 32'(bus.altair_waddr), 0);
    chk({tag, "_wdata"}, 32'(bus.altair_wdata), 0);
    chk({tag, "_hold"},  32'(bus.cpu_hold), 0);
    chk({tag, "_done"},  32'(bus.load_done), 0);
    chk({tag, "_err"},   32'(bus.load_error), 0);
  endtask

  // Write monitor: every strobe must match the next expected write, one line per transaction.
  always @(negedge clk) begin
    wr_t w;
    if (bus.load_done) done_cnt++;
    if (bus.altair_we) begin
      if (exp_wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", bus.altair_waddr, bus.altair_wdata);
      end else begin
        w = exp_wq.pop_front();
        $display("write addr=%04h data=%04h (expected %04h/%04h)", bus.altair_waddr, bus.altair_wdata, w.addr, w.data);
        chk("write_addr", 32'(bus.altair_waddr), 32'(w.addr));
        chk("write_data", 32'(bus.altair_wdata), 32'(w.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    //            addr      n  bad gap done err hold
    vecs[0] = '{16'h0000, 3, 0, 0, 1, 0, 0};
    vecs[1] = '{16'h3FFE, 4, 0, 6, 1, 0, 0};
    vecs[2] = '{16'hC123, 2, 0, 12, 1, 0, 0};
    vecs[3] = '{16'hFFFF, 3, 0, 3, 1, 0, 0};
    vecs[4] = '{16'h1234, 2, 1, 4, 0, 1, 1};
    vecs[5] = '{16'h0100, 5, 0, 2, 1, 0, 0};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.rx_ready), 1);

    // Basic single-word load with write-latency checks.
    expect_write(32'h0010, 16'h1234);
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h12};
    send_q(0);
    chk("hold_during_load", 32'(bus.cpu_hold), 1);
    send_byte(8'h34);
    chk("we_latency", 32'(bus.altair_we), 1);
    chk("we_addr_basic", 32'(bus.altair_waddr), 32'h0010);
    chk("we_data_basic", 32'(bus.altair_wdata), 32'h1234);
    @(negedge clk);
    chk("we_single_cycle", 32'(bus.altair_we), 0);
    d0 = done_cnt;
    send_byte(8'h37);
    chk("basic_done", 32'(bus.load_done), 1);
    chk("basic_hold", 32'(bus.cpu_hold), 0);
    chk("basic_err", 32'(bus.load_error), 0);
    idle(2);
    chk("basic_done_count", 32'(done_cnt - d0), 1);

    // Multi-word load wrapping past the top of memory.
    expect_write(32'h3FFF, 16'hAABB);
    expect_write(32'h0000, 16'hCCDD);
    frame_q = '{8'hA5, 8'h3F, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    frame_q.push_back(frame_xor());
    d0 = done_cnt;
    send_q(0);
    chk("wrap_done", 32'(bus.load_done), 1);
    idle(2);
    chk("wrap_done_count", 32'(done_cnt - d0), 1);

    // Bad checksum: write still happens, error sticks, CPU stays held.
    expect_write(32'h0010, 16'h1234);
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h12, 8'h34, 8'h36};
    d0 = done_cnt;
    send_q(0);
    chk("bad_err", 32'(bus.load_error), 1);
    chk("bad_hold", 32'(bus.cpu_hold), 1);
    idle(3);
    chk("bad_no_done", 32'(done_cnt - d0), 0);
    chk("bad_err_sticky", 32'(bus.load_error), 1);

    // Zero-count frame, also the good frame that recovers from the error.
    d0 = done_cnt;
    send_byte(8'hA5);
    chk("sync_clears_err", 32'(bus.load_error), 0);
    frame_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    send_q(0);
    chk("zero_done", 32'(bus.load_done), 1);
    chk("zero_hold", 32'(bus.cpu_hold), 0);
    idle(2);
    chk("zero_done_count", 32'(done_cnt - d0), 1);

    // Timeout after 16 idle cycles, then garbage is ignored.
    send_byte(8'hA5);
    send_byte(8'h00);
    idle(15);
    chk("timeout_not_yet", 32'(bus.load_error), 0);
    idle(1);
    chk("timeout_err", 32'(bus.load_error), 1);
    chk("timeout_hold", 32'(bus.cpu_hold), 1);
    frame_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'hFF};
    send_q(1);
    idle(2);
    chk("garbage_err_kept", 32'(bus.load_error), 1);

    // Reset between DATA_HI and DATA_LO.
    frame_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h02, 8'h11};
    send_q(0);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h22);
    chk("midrst_no_write", 32'(bus.altair_we), 0);
    idle(2);

    // Randomized frames from the table.
    for (int v = 0; v < 6; v++) begin
      make_frame(vecs[v].addr, vecs[v].nwords, vecs[v].bad);
      d0 = done_cnt;
      send_q(vecs[v].max_gap);
      $display("frame %0d addr=%04h n=%0d bad=%0d done=%0d err=%0d hold=%0d", v, vecs[v].addr,
               vecs[v].nwords, vecs[v].bad, bus.load_done, bus.load_error, bus.cpu_hold);
      chk($sformatf("vec%0d_done", v), 32'(bus.load_done), 32'(vecs[v].exp_done));
      chk($sformatf("vec%0d_err", v), 32'(bus.load_error), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_hold", v), 32'(bus.cpu_hold), 32'(vecs[v].exp_hold));
      idle(2);
      chk($sformatf("vec%0d_done_count", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done));
      chk($sformatf("vec%0d_writes_pending", v), 32'(exp_wq.size()), 0);
    end

    idle(4);
    chk("writes_left", 32'(exp_wq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
